// File: rtl/uart_word_link.sv
// rtl/uart_word_link.sv - UART endpoint moving DATA_WIDTH-bit words as LSB-first byte frames
module uart_word_link_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot that a push into a full FIFO needs.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module uart_word_link #(
    parameter int DATA_WIDTH   = 32,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                  uart_clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic                  tx,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_ready,
    output logic                  tx_busy,
    input  logic                  clear_err,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overflow
);
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int IDX_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W      = $clog2(TMO_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES - 1);
    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMO_W-1:0] TMO_END   = TMO_W'(TMO_CYCLES - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    // ---------------- transmit path ----------------
    logic [DATA_WIDTH-1:0] tx_fifo_data;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  tx_pop;

    tx_state_t             tx_state;
    logic [CNT_W-1:0]      tx_cnt;
    logic [2:0]            tx_bit;
    logic                  tx_stop_n;
    logic [IDX_W-1:0]      tx_idx;
    logic [7:0]            tx_byte;
    logic [DATA_WIDTH-1:0] tx_word;
    logic                  tx_bit_end;
    logic                  tx_word_end;
    logic                  tx_level;

    assign tx_ready    = !tx_full;
    assign tx_busy     = !tx_empty || (tx_state != TX_IDLE);
    assign tx_bit_end  = (tx_cnt == BIT_END);
    assign tx_word_end = (tx_state == TX_STOP) && tx_bit_end && (tx_stop_n == STOP_LAST) &&
                         (tx_idx == LAST_IDX);
    assign tx_pop      = !tx_empty && ((tx_state == TX_IDLE) || tx_word_end);

    uart_word_link_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (uart_clk),
        .rst_n (rst_n),
        .push  (tx_valid && tx_ready),
        .wdata (tx_data),
        .pop   (tx_pop),
        .rdata (tx_fifo_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_comb begin
        tx_level = 1'b1;
        case (tx_state)
            TX_START:  tx_level = 1'b0;
            TX_DATA:   tx_level = tx_byte[tx_bit];
            TX_PARITY: tx_level = (^tx_byte) ^ ODD_PAR;
            default:   tx_level = 1'b1;
        endcase
    end

    // tx is the registered line level, so each bit lags its state by one cycle uniformly.
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx        <= 1'b1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_stop_n <= 1'b0;
            tx_idx    <= '0;
            tx_byte   <= '0;
            tx_word   <= '0;
        end else begin
            tx <= tx_level;
            if (tx_state == TX_IDLE || tx_bit_end) tx_cnt <= '0;
            else                                   tx_cnt <= tx_cnt + 1'b1;

            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_byte  <= tx_fifo_data[7:0];
                        tx_word  <= tx_fifo_data >> 8;
                        tx_idx   <= '0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_bit   <= '0;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit == 3'd7) begin
                            tx_stop_n <= 1'b0;
                            tx_state  <= (PARITY != 0) ? TX_PARITY : TX_STOP;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_stop_n <= 1'b0;
                        tx_state  <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        if (tx_stop_n != STOP_LAST) begin
                            tx_stop_n <= 1'b1;
                        end else if (tx_idx != LAST_IDX) begin
                            tx_idx   <= tx_idx + 1'b1;
                            tx_byte  <= tx_word[7:0];
                            tx_word  <= tx_word >> 8;
                            tx_state <= TX_START;
                        end else if (tx_pop) begin
                            tx_byte  <= tx_fifo_data[7:0];
                            tx_word  <= tx_fifo_data >> 8;
                            tx_idx   <= '0;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receive path ----------------
    logic [1:0]            rx_sync;
    logic                  rx_s;
    logic                  rx_prev;

    rx_state_t             rx_state;
    logic [CNT_W-1:0]      rx_cnt;
    logic [2:0]            rx_bit;
    logic [7:0]            rx_byte;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [IDX_W-1:0]      rx_idx;
    logic                  rx_push;
    logic [TMO_W-1:0]      tmo_cnt;
    logic                  rx_full;
    logic                  rx_empty;
    logic                  rx_bit_end;
    logic                  rx_par_exp;

    assign rx_s       = rx_sync[1];
    assign rx_valid   = !rx_empty;
    assign rx_bit_end = (rx_cnt == BIT_END);
    assign rx_par_exp = (^rx_byte) ^ ODD_PAR;

    uart_word_link_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (uart_clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .wdata (rx_word),
        .pop   (rx_ready),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_s;
        end
    end

    // Error sets are written after the clear so a simultaneous new error keeps its flag.
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_byte    <= '0;
            rx_word    <= '0;
            rx_idx     <= '0;
            rx_push    <= 1'b0;
            tmo_cnt    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            if (clear_err) begin
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overflow   <= 1'b0;
            end
            if (rx_push && rx_full && !(rx_ready && rx_valid)) overflow <= 1'b1;

            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                    end else if (rx_idx != '0) begin
                        if (tmo_cnt == TMO_END) begin
                            frame_err <= 1'b1;
                            rx_idx    <= '0;
                            tmo_cnt   <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt  <= '0;
                        rx_byte <= {rx_s, rx_byte[7:1]};
                        if (rx_bit == 3'd7) rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (rx_bit_end) begin
                        rx_cnt <= '0;
                        if (rx_s != rx_par_exp) begin
                            parity_err <= 1'b1;
                            rx_idx     <= '0;
                            rx_state   <= RX_IDLE;
                        end else begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt <= '0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            rx_idx    <= '0;
                            rx_state  <= RX_WAIT_HIGH;
                        end else begin
                            rx_word[{rx_idx, 3'b000} +: 8] <= rx_byte;
                            tmo_cnt  <= '0;
                            rx_state <= RX_IDLE;
                            if (rx_idx == LAST_IDX) begin
                                rx_idx  <= '0;
                                rx_push <= 1'b1;
                            end else begin
                                rx_idx <= rx_idx + 1'b1;
                            end
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_word_link.sv
// tb/tb_uart_word_link.sv - directed bench for uart_word_link, default and 16-bit/no-parity builds
module tb_uart_word_link;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // DUT A: defaults, rx either looped from tx or driven by the bench
    logic        rst_n = 1'b1;
    logic        loop_a = 1'b0;
    logic        drv_rx_a = 1'b1;
    logic        rx_a, tx_a;
    logic        tx_valid_a = 1'b0;
    logic [31:0] tx_data_a = '0;
    logic        tx_ready_a, rx_valid_a, tx_busy_a;
    logic [31:0] rx_data_a;
    logic        rx_ready_a = 1'b0;
    logic        clear_err_a = 1'b0;
    logic        parity_err_a, frame_err_a, overflow_a;

    assign rx_a = loop_a ? tx_a : drv_rx_a;

    uart_word_link dut_a (
        .uart_clk(clk), .rst_n(rst_n), .rx(rx_a), .tx(tx_a),
        .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
        .rx_valid(rx_valid_a), .rx_data(rx_data_a), .rx_ready(rx_ready_a),
        .tx_busy(tx_busy_a), .clear_err(clear_err_a), .parity_err(parity_err_a),
        .frame_err(frame_err_a), .overflow(overflow_a)
    );

    // DUT B: 16-bit words, no parity, two stop bits, looped back
    logic        rst_b_n = 1'b1;
    logic        tx_b;
    logic        tx_valid_b = 1'b0;
    logic [15:0] tx_data_b = '0;
    logic        tx_ready_b, rx_valid_b, tx_busy_b;
    logic [15:0] rx_data_b;
    logic        rx_ready_b = 1'b0;
    logic        clear_err_b = 1'b0;
    logic        parity_err_b, frame_err_b, overflow_b;

    uart_word_link #(.DATA_WIDTH(16), .PARITY(0), .STOP_BITS(2)) dut_b (
        .uart_clk(clk), .rst_n(rst_b_n), .rx(tx_b), .tx(tx_b),
        .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
        .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_ready(rx_ready_b),
        .tx_busy(tx_busy_b), .clear_err(clear_err_b), .parity_err(parity_err_b),
        .frame_err(frame_err_b), .overflow(overflow_b)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         t;
    } frame_t;

    frame_t mon_a[$];
    frame_t mon_b[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic line_of(input bit sel_b);
        return sel_b ? tx_b : tx_a;
    endfunction

    task automatic decode_frame(input bit sel_b, input bit has_par, input int nstop,
                                output frame_t f);
        do @(negedge clk); while (line_of(sel_b) !== 1'b0);
        f.t = cyc;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            f.data[i] = line_of(sel_b);
        end
        f.par = 1'b0;
        if (has_par) begin
            repeat (16) @(negedge clk);
            f.par = line_of(sel_b);
        end
        f.stop = 1'b1;
        for (int s = 0; s < nstop; s++) begin
            repeat (16) @(negedge clk);
            if (line_of(sel_b) !== 1'b1) f.stop = 1'b0;
        end
    endtask

    initial begin : mon_a_proc
        frame_t f;
        @(posedge rst_n);
        forever begin
            decode_frame(1'b0, 1'b1, 1, f);
            mon_a.push_back(f);
        end
    end

    initial begin : mon_b_proc
        frame_t f;
        @(posedge rst_b_n);
        forever begin
            decode_frame(1'b1, 1'b0, 2, f);
            mon_b.push_back(f);
        end
    end

    task automatic push_a(input logic [31:0] w, output int t_acc);
        int n = 0;
        @(negedge clk);
        tx_valid_a = 1'b1;
        tx_data_a  = w;
        while (!tx_ready_a && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("push_ready_wait", tx_ready_a, 1);
        @(posedge clk);
        #1;
        t_acc      = cyc;
        tx_valid_a = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        drv_rx_a = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic p, input logic s);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(p);
        drive_bit(s);
        drv_rx_a = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], ^w[8*k +: 8], 1'b1);
    endtask

    task automatic wait_valid(input bit sel_b, input int max);
        int n = 0;
        while (!(sel_b ? rx_valid_b : rx_valid_a) && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pop_a;
        @(negedge clk);
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
    endtask

    task automatic pulse_clear;
        @(negedge clk);
        clear_err_a = 1'b1;
        @(negedge clk);
        clear_err_a = 1'b0;
    endtask

    logic [7:0]  exp_byte [4];
    logic        exp_par  [4];
    logic [31:0] ow       [6];
    int          t_acc;
    int          n;

    initial begin
        exp_byte = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp_par  = '{1'b1, 1'b0, 1'b1, 1'b0};
        ow       = '{32'h0BADF00D, 32'h12345678, 32'hCAFEBABE,
                     32'h00FF00FF, 32'h55AA55AA, 32'hFEEDFACE};

        #2;
        rst_n   = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_tx_ready", tx_ready_a, 1);
        check("rst_rx_valid", rx_valid_a, 0);
        check("rst_rx_data", rx_data_a, 0);
        check("rst_tx_busy", tx_busy_a, 0);
        check("rst_errs", {parity_err_a, frame_err_a, overflow_a}, 0);
        rst_n   = 1'b1;
        rst_b_n = 1'b1;
        repeat (2) @(negedge clk);

        // loopback of one word: byte order, parity bits, frame spacing, busy window
        loop_a = 1'b1;
        push_a(32'hDEADBEEF, t_acc);
        n = 0;
        while (mon_a.size() < 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("lb_frame_count", mon_a.size(), 4);
        check("lb_first_fall", 64'(mon_a[0].t - t_acc), 2);
        for (int i = 0; i < 4; i++) begin
            if (i < mon_a.size()) begin
                check($sformatf("lb_byte%0d", i), mon_a[i].data, exp_byte[i]);
                check($sformatf("lb_par%0d", i), mon_a[i].par, exp_par[i]);
                check($sformatf("lb_stop%0d", i), mon_a[i].stop, 1);
                check($sformatf("lb_spacing%0d", i), 64'(mon_a[i].t - mon_a[0].t), 64'(176 * i));
            end
        end
        wait_cyc(t_acc + 704);
        check("lb_busy_last", tx_busy_a, 1);
        wait_cyc(t_acc + 705);
        check("lb_busy_done", tx_busy_a, 0);
        wait_valid(1'b0, 300);
        check("lb_rx_valid", rx_valid_a, 1);
        check("lb_rx_data", rx_data_a, 32'hDEADBEEF);
        check("lb_errs", {parity_err_a, frame_err_a, overflow_a}, 0);
        pop_a();
        check("lb_popped", rx_valid_a, 0);

        // bad parity on a single byte, then recovery
        loop_a = 1'b0;
        send_byte(8'h55, 1'b1, 1'b1);
        repeat (32) @(negedge clk);
        check("par_err_set", parity_err_a, 1);
        check("par_no_valid", rx_valid_a, 0);
        check("par_no_frame", frame_err_a, 0);
        pulse_clear();
        check("par_err_clear", parity_err_a, 0);
        send_word(32'h12345678);
        wait_valid(1'b0, 300);
        check("par_next_word", rx_data_a, 32'h12345678);
        check("par_next_errs", {parity_err_a, frame_err_a}, 0);
        pop_a();

        // low stop bit on the third byte, then an intact word
        send_byte(8'hDD, ^8'hDD, 1'b1);
        send_byte(8'hCC, ^8'hCC, 1'b1);
        send_byte(8'hBB, ^8'hBB, 1'b0);
        repeat (32) @(negedge clk);
        check("frm_err_set", frame_err_a, 1);
        check("frm_no_valid", rx_valid_a, 0);
        pulse_clear();
        check("frm_err_clear", frame_err_a, 0);
        send_word(32'h01020304);
        wait_valid(1'b0, 300);
        check("frm_next_word", rx_data_a, 32'h01020304);
        check("frm_next_errs", {parity_err_a, frame_err_a}, 0);
        pop_a();

        // six looped words into a four-deep RX FIFO with no consumer
        loop_a = 1'b1;
        for (int i = 0; i < 6; i++) push_a(ow[i], t_acc);
        n = 0;
        while (tx_busy_a && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("ovf_tx_drained", tx_busy_a, 0);
        repeat (300) @(negedge clk);
        check("ovf_flag", overflow_a, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_valid%0d", i), rx_valid_a, 1);
            check($sformatf("ovf_word%0d", i), rx_data_a, ow[i]);
            pop_a();
        end
        check("ovf_empty", rx_valid_a, 0);
        check("ovf_other_errs", {parity_err_a, frame_err_a}, 0);
        pulse_clear();
        check("ovf_cleared", overflow_a, 0);

        // idle-line glitch, then a partial word that times out
        loop_a = 1'b0;
        @(negedge clk);
        drv_rx_a = 1'b0;
        repeat (5) @(negedge clk);
        drv_rx_a = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_errs", {parity_err_a, frame_err_a, overflow_a}, 0);
        check("glitch_no_valid", rx_valid_a, 0);
        send_byte(8'h11, ^8'h11, 1'b1);
        send_byte(8'h22, ^8'h22, 1'b1);
        repeat (470) @(negedge clk);
        check("tmo_not_yet", frame_err_a, 0);
        repeat (80) @(negedge clk);
        check("tmo_frame_err", frame_err_a, 1);
        check("tmo_no_valid", rx_valid_a, 0);
        pulse_clear();
        send_word(32'hCAFEF00D);
        wait_valid(1'b0, 300);
        check("tmo_next_word", rx_data_a, 32'hCAFEF00D);
        check("tmo_next_errs", {parity_err_a, frame_err_a}, 0);
        pop_a();

        // 16-bit, no parity, two stop bits
        @(negedge clk);
        check("b_ready", tx_ready_b, 1);
        tx_valid_b = 1'b1;
        tx_data_b  = 16'hA5C3;
        @(posedge clk);
        #1;
        t_acc      = cyc;
        tx_valid_b = 1'b0;
        n = 0;
        while (mon_b.size() < 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("b_frame_count", mon_b.size(), 2);
        check("b_first_fall", 64'(mon_b[0].t - t_acc), 2);
        check("b_byte0", mon_b[0].data, 8'hC3);
        check("b_byte1", mon_b[1].data, 8'hA5);
        check("b_stops", {mon_b[0].stop, mon_b[1].stop}, 2'b11);
        check("b_spacing", 64'(mon_b[1].t - mon_b[0].t), 176);
        wait_valid(1'b1, 300);
        check("b_rx_data", rx_data_b, 16'hA5C3);
        check("b_errs", {parity_err_b, frame_err_b, overflow_b}, 0);
        @(negedge clk);
        rx_ready_b = 1'b1;
        @(negedge clk);
        rx_ready_b = 1'b0;

        // asynchronous reset while a zero data bit is on the line
        tx_valid_b = 1'b1;
        tx_data_b  = 16'h0000;
        @(posedge clk);
        #1;
        t_acc      = cyc;
        tx_valid_b = 1'b0;
        wait_cyc(t_acc + 58);
        check("b_mid_data_low", tx_b, 0);
        check("b_mid_busy", tx_busy_b, 1);
        #3;
        rst_b_n = 1'b0;
        #1;
        check("b_rst_tx", tx_b, 1);
        check("b_rst_ready", tx_ready_b, 1);
        check("b_rst_busy", tx_busy_b, 0);
        check("b_rst_valid", rx_valid_b, 0);
        @(negedge clk);
        rst_b_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
